// File: rtl/hpu_dm_trig_prog.sv
// Debug-mode trigger programming sequencer. It writes tselect/tdata1-3 over the CSR bus,
// reads tdata1/tdata2 back, and flags a tdata2 read-back mismatch or a debug-mode abort.

localparam int unsigned HPU_XLEN   = 32;
localparam int unsigned CSR_ADDR_W = 12;

localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_DBG_TSELECT = 12'h7A0;
localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_DBG_TDATA1  = 12'h7A1;
localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_DBG_TDATA2  = 12'h7A2;
localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_DBG_TDATA3  = 12'h7A3;

typedef logic [HPU_XLEN-1:0] data_t;

typedef struct packed {
    logic                  wr_en;
    logic [CSR_ADDR_W-1:0] waddr;
    data_t                 wdata;
    logic                  rd_en;
    logic [CSR_ADDR_W-1:0] raddr;
} csr_bus_req_t;

typedef struct packed {
    data_t rdata;
} csr_bus_rsp_t;

module hpu_dm_trig_prog #(
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned TRIG_NUM_BIT = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ctrl__hpu_dmode_i,
    input  logic                    cmd_vld_i,
    output logic                    cmd_rdy_o,
    input  logic                    cmd_wr_i,
    input  logic [TRIG_NUM_BIT-1:0] cmd_idx_i,
    input  data_t                   cmd_tdata1_i,
    input  data_t                   cmd_tdata2_i,
    input  data_t                   cmd_tdata3_i,
    output logic                    rsp_vld_o,
    input  logic                    rsp_rdy_i,
    output data_t                   rsp_tdata1_o,
    output data_t                   rsp_tdata2_o,
    output logic                    rsp_err_o,
    output csr_bus_req_t            csr_trig__bus_req_o,
    input  csr_bus_rsp_t            trig_csr__bus_rsp_i
);

    // The capture points below assume rdata lands exactly one cycle after rd_en.
    if (RD_LAT != 1) begin : g_rd_lat_chk
        $error("hpu_dm_trig_prog: only RD_LAT == 1 is supported");
    end

    typedef enum logic [3:0] {
        IDLE,
        WR_TSEL,
        WR_TD1,
        WR_TD2,
        WR_TD3,
        RD_TD1,
        RD_TD2,
        RD_WAIT,
        RSP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept_c;
    logic                    abort_c;
    logic                    busy_c;

    logic                    wr_q;
    logic [TRIG_NUM_BIT-1:0] idx_q;
    data_t                   td1_q;
    data_t                   td2_q;
    data_t                   td3_q;

    data_t                   rsp_td1_q;
    data_t                   rsp_td2_q;
    logic                    rsp_err_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus request decode; a dropped debug mode suppresses this cycle's access
    always_comb begin
        state_d             = state_q;
        csr_trig__bus_req_o = '0;
        accept_c            = 1'b0;
        abort_c             = 1'b0;
        busy_c              = (state_q != IDLE) && (state_q != RSP);

        case (state_q)
            IDLE: begin
                if (cmd_vld_i) begin
                    accept_c = 1'b1;
                    state_d  = ctrl__hpu_dmode_i ? WR_TSEL : RSP;
                end
            end
            WR_TSEL: begin
                csr_trig__bus_req_o.wr_en = 1'b1;
                csr_trig__bus_req_o.waddr = CSR_ADDR_DBG_TSELECT;
                csr_trig__bus_req_o.wdata = HPU_XLEN'(idx_q);
                state_d                   = wr_q ? WR_TD1 : RD_TD1;
            end
            WR_TD1: begin
                csr_trig__bus_req_o.wr_en = 1'b1;
                csr_trig__bus_req_o.waddr = CSR_ADDR_DBG_TDATA1;
                csr_trig__bus_req_o.wdata = td1_q;
                state_d                   = WR_TD2;
            end
            WR_TD2: begin
                csr_trig__bus_req_o.wr_en = 1'b1;
                csr_trig__bus_req_o.waddr = CSR_ADDR_DBG_TDATA2;
                csr_trig__bus_req_o.wdata = td2_q;
                state_d                   = WR_TD3;
            end
            WR_TD3: begin
                csr_trig__bus_req_o.wr_en = 1'b1;
                csr_trig__bus_req_o.waddr = CSR_ADDR_DBG_TDATA3;
                csr_trig__bus_req_o.wdata = td3_q;
                state_d                   = RD_TD1;
            end
            RD_TD1: begin
                csr_trig__bus_req_o.rd_en = 1'b1;
                csr_trig__bus_req_o.raddr = CSR_ADDR_DBG_TDATA1;
                state_d                   = RD_TD2;
            end
            RD_TD2: begin
                csr_trig__bus_req_o.rd_en = 1'b1;
                csr_trig__bus_req_o.raddr = CSR_ADDR_DBG_TDATA2;
                state_d                   = RD_WAIT;
            end
            RD_WAIT: begin
                state_d = RSP;
            end
            RSP: begin
                if (rsp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (busy_c && !ctrl__hpu_dmode_i) begin
            abort_c             = 1'b1;
            csr_trig__bus_req_o = '0;
            state_d             = RSP;
        end
    end

    // Command latch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= 1'b0;
            idx_q <= '0;
            td1_q <= '0;
            td2_q <= '0;
            td3_q <= '0;
        end else if (accept_c) begin
            wr_q  <= cmd_wr_i;
            idx_q <= cmd_idx_i;
            td1_q <= cmd_tdata1_i;
            td2_q <= cmd_tdata2_i;
            td3_q <= cmd_tdata3_i;
        end
    end

    // Read-back capture; tdata1 is not compared since its hit bits are set by hardware
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_td1_q <= '0;
            rsp_td2_q <= '0;
            rsp_err_q <= 1'b0;
        end else if (accept_c) begin
            rsp_err_q <= !ctrl__hpu_dmode_i;
        end else if (abort_c) begin
            rsp_err_q <= 1'b1;
        end else if (state_q == RD_TD2) begin
            rsp_td1_q <= trig_csr__bus_rsp_i.rdata;
        end else if (state_q == RD_WAIT) begin
            rsp_td2_q <= trig_csr__bus_rsp_i.rdata;
            rsp_err_q <= wr_q && (trig_csr__bus_rsp_i.rdata != td2_q);
        end
    end

    assign cmd_rdy_o    = (state_q == IDLE);
    assign rsp_vld_o    = (state_q == RSP);
    assign rsp_tdata1_o = rsp_td1_q;
    assign rsp_tdata2_o = rsp_td2_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_hpu_dm_trig_prog.sv
// Randomized bench for hpu_dm_trig_prog: a CSR responder plus a transaction-level model
// that predicts the bus trace, response latency and read-back values of each command.

module tb_hpu_dm_trig_prog;

    localparam int unsigned NTRIG = 4;
    localparam logic [11:0] A_TSEL = 12'h7A0;
    localparam logic [11:0] A_TD1  = 12'h7A1;
    localparam logic [11:0] A_TD2  = 12'h7A2;
    localparam logic [11:0] A_TD3  = 12'h7A3;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [11:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmode;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        cmd_wr;
    logic [1:0]  cmd_idx;
    logic [31:0] cmd_td1;
    logic [31:0] cmd_td2;
    logic [31:0] cmd_td3;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_td1;
    logic [31:0] rsp_td2;
    logic        rsp_err;
    logic [57:0] bus_req;
    logic [31:0] bus_rsp = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    // Responder storage (environment) and model storage (prediction)
    logic [31:0] r_td1[NTRIG];
    logic [31:0] r_td2[NTRIG];
    logic [31:0] r_td3[NTRIG];
    logic [1:0]  r_tsel = 2'd0;
    bit          r_ign = 1'b0;
    logic [31:0] m_td1[NTRIG];
    logic [31:0] m_td2[NTRIG];
    logic [31:0] m_td3[NTRIG];
    int          m_tsel = 0;

    always #5 clk = ~clk;

    hpu_dm_trig_prog #(
        .RD_LAT       (1),
        .TRIG_NUM_BIT (2)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ctrl__hpu_dmode_i   (dmode),
        .cmd_vld_i           (cmd_vld),
        .cmd_rdy_o           (cmd_rdy),
        .cmd_wr_i            (cmd_wr),
        .cmd_idx_i           (cmd_idx),
        .cmd_tdata1_i        (cmd_td1),
        .cmd_tdata2_i        (cmd_td2),
        .cmd_tdata3_i        (cmd_td3),
        .rsp_vld_o           (rsp_vld),
        .rsp_rdy_i           (rsp_rdy),
        .rsp_tdata1_o        (rsp_td1),
        .rsp_tdata2_o        (rsp_td2),
        .rsp_err_o           (rsp_err),
        .csr_trig__bus_req_o (bus_req),
        .trig_csr__bus_rsp_i (bus_rsp)
    );

    // CSR responder: {wr_en[57], waddr[56:45], wdata[44:13], rd_en[12], raddr[11:0]}
    always @(posedge clk) begin
        if (bus_req[57]) begin
            case (bus_req[56:45])
                A_TSEL:  r_tsel = bus_req[14:13];
                A_TD1:   r_td1[r_tsel] = bus_req[44:13];
                A_TD2:   if (!r_ign) r_td2[r_tsel] = bus_req[44:13];
                A_TD3:   r_td3[r_tsel] = bus_req[44:13];
                default: ;
            endcase
        end
        if (bus_req[12]) begin
            case (bus_req[11:0])
                A_TD1:   bus_rsp <= r_td1[r_tsel];
                A_TD2:   bus_rsp <= r_td2[r_tsel];
                default: bus_rsp <= 32'hDEAD_BEEF;
            endcase
        end else begin
            bus_rsp <= 32'd0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic resync();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(NTRIG); i++) begin
            m_td1[i] = r_td1[i];
            m_td2[i] = r_td2[i];
            m_td3[i] = r_td3[i];
        end
        m_tsel = int'(r_tsel);
    endtask

    function automatic logic [57:0] op_vec(input op_t op);
        return {op.wr, op.wr ? op.addr : 12'd0, op.wr ? op.data : 32'd0,
                op.rd, op.rd ? op.addr : 12'd0};
    endfunction

    // abort_k: index of the bus operation during which dmode drops (-1 = none)
    task automatic run_cmd(input bit wr, input logic [1:0] idx, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input bit dm,
                           input int abort_k, input bit ign, input int hold);
        op_t         ops[$];
        int          n_app;
        int          lat;
        int          err0;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          eerr;
        bit          data_ok;
        logic [57:0] ebus;

        err0 = n_errors;
        e1   = 32'd0;
        e2   = 32'd0;
        ops.push_back('{1'b1, 1'b0, A_TSEL, {30'd0, idx}});
        if (wr) begin
            ops.push_back('{1'b1, 1'b0, A_TD1, d1});
            ops.push_back('{1'b1, 1'b0, A_TD2, d2});
            ops.push_back('{1'b1, 1'b0, A_TD3, d3});
        end
        ops.push_back('{1'b0, 1'b1, A_TD1, 32'd0});
        ops.push_back('{1'b0, 1'b1, A_TD2, 32'd0});

        n_app = !dm ? 0 : (abort_k >= 0 ? abort_k : ops.size());
        for (int i = 0; i < n_app; i++) begin
            if (ops[i].wr) begin
                case (ops[i].addr)
                    A_TSEL:  m_tsel = int'(ops[i].data);
                    A_TD1:   m_td1[m_tsel] = ops[i].data;
                    A_TD2:   if (!ign) m_td2[m_tsel] = ops[i].data;
                    default: m_td3[m_tsel] = ops[i].data;
                endcase
            end else if (ops[i].addr == A_TD1) begin
                e1 = m_td1[m_tsel];
            end else begin
                e2 = m_td2[m_tsel];
            end
        end
        data_ok = dm && (abort_k < 0);
        eerr    = !data_ok || (wr && (e2 != d2));
        lat     = !dm ? 1 : (abort_k >= 0 ? abort_k + 2 : ops.size() + 2);

        @(negedge clk);
        r_ign   = ign;
        rsp_rdy = 1'b0;
        cmd_vld = 1'b1;
        cmd_wr  = wr;
        cmd_idx = idx;
        cmd_td1 = d1;
        cmd_td2 = d2;
        cmd_td3 = d3;
        dmode   = dm;
        chk("cmd_rdy_idle", 64'(cmd_rdy), 64'(1));
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        cmd_wr  = 1'($urandom);
        cmd_idx = 2'($urandom);
        cmd_td1 = $urandom;
        cmd_td2 = $urandom;
        cmd_td3 = $urandom;

        for (int c = 1; c <= lat; c++) begin
            if (abort_k >= 0 && c == abort_k + 1) dmode = 1'b0;
            @(negedge clk);
            ebus = '0;
            if (c - 1 < n_app) ebus = op_vec(ops[c-1]);
            chk("bus_req", 64'(bus_req), 64'(ebus));
            chk("rsp_vld_seq", 64'(rsp_vld), 64'(c == lat));
            chk("cmd_rdy_busy", 64'(cmd_rdy), 64'(0));
            if (c < lat) begin
                @(posedge clk);
                #1;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk("rsp_vld_hold", 64'(rsp_vld), 64'(1));
            chk("rsp_err", 64'(rsp_err), 64'(eerr));
            chk("bus_idle_rsp", 64'(bus_req), 64'(0));
            if (data_ok) begin
                chk("rsp_tdata1", 64'(rsp_td1), 64'(e1));
                chk("rsp_tdata2", 64'(rsp_td2), 64'(e2));
            end
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        dmode   = 1'b1;
        r_ign   = 1'b0;
        chk("cmd_rdy_after", 64'(cmd_rdy), 64'(1));
        chk("rsp_vld_after", 64'(rsp_vld), 64'(0));
        if (n_errors != err0) resync();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'(1));
        chk({tag, "_rsp_vld"}, 64'(rsp_vld), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, "_rsp_td1"}, 64'(rsp_td1), 64'(0));
        chk({tag, "_rsp_td2"}, 64'(rsp_td2), 64'(0));
        chk({tag, "_bus"}, 64'(bus_req), 64'(0));
    endtask

    // Write command interrupted by reset while the tdata1 read is on the bus
    task automatic rst_mid();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        d1 = $urandom;
        d2 = $urandom;
        d3 = $urandom;
        @(negedge clk);
        cmd_vld = 1'b1;
        cmd_wr  = 1'b1;
        cmd_idx = 2'd2;
        cmd_td1 = d1;
        cmd_td2 = d2;
        cmd_td3 = d3;
        dmode   = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_pos", 64'(bus_req), 64'({1'b0, 12'd0, 32'd0, 1'b1, A_TD1}));
        rst = 1'b1;
        #1;
        chk_reset_state("rst_async");
        @(posedge clk);
        #1;
        chk_reset_state("rst_edge");
        @(negedge clk);
        rst    = 1'b0;
        m_tsel = 2;
        m_td1[2] = d1;
        m_td2[2] = d2;
        m_td3[2] = d3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_replay_bus", 64'(bus_req), 64'(0));
            chk("no_replay_rdy", 64'(cmd_rdy), 64'(1));
        end
    endtask

    initial begin
        logic [31:0] v;
        bit          wr;
        int          nops;
        int          ab;

        rst     = 1'b1;
        dmode   = 1'b1;
        cmd_vld = 1'b0;
        cmd_wr  = 1'b0;
        cmd_idx = 2'd0;
        cmd_td1 = 32'd0;
        cmd_td2 = 32'd0;
        cmd_td3 = 32'd0;
        rsp_rdy = 1'b0;
        for (int i = 0; i < int'(NTRIG); i++) begin
            v = $urandom; r_td1[i] = v; m_td1[i] = v;
            v = $urandom; r_td2[i] = v; m_td2[i] = v;
            v = $urandom; r_td3[i] = v; m_td3[i] = v;
        end
        r_td2[0] = 32'h0000_1234;
        m_td2[0] = 32'h0000_1234;

        repeat (2) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;

        run_cmd(1'b1, 2'd1, 32'h2000_0044, 32'h8000_0100, 32'h0, 1'b1, -1, 1'b0, 0);
        run_cmd(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1, -1, 1'b0, 0);
        run_cmd(1'b1, 2'd3, $urandom, $urandom, $urandom, 1'b0, -1, 1'b0, 0);
        run_cmd(1'b0, 2'd2, $urandom, $urandom, $urandom, 1'b0, -1, 1'b0, 1);
        run_cmd(1'b1, 2'd2, $urandom, $urandom, $urandom, 1'b1, 2, 1'b0, 0);
        run_cmd(1'b1, 2'd3, $urandom, $urandom, $urandom, 1'b1, -1, 1'b0, 5);
        run_cmd(1'b0, 2'd3, $urandom, $urandom, $urandom, 1'b1, -1, 1'b0, 0);
        run_cmd(1'b1, 2'd1, 32'h2000_0044, 32'h8000_0100, 32'h0, 1'b1, -1, 1'b0, 0);
        run_cmd(1'b1, 2'd0, 32'h2000_0044, 32'h8000_0100, 32'h5, 1'b1, -1, 1'b1, 0);
        rst_mid();

        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom);
            nops = wr ? 6 : 3;
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nops - 1)) : -1;
            run_cmd(wr, 2'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 7) != 0, ab, $urandom_range(0, 5) == 0,
                    int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
